// File: rtl/serial_addsub_flags.sv
// -----------------------------------------------------------------------------
// serial_addsub_flags
//   Bit-serial signed two's-complement adder/subtractor. One bit is processed
//   per clock, LSB first. The unit returns the result together with the
//   overflow, carry, negative and zero flags. Operands arrive on a
//   valid/ready request channel. Results leave on a valid/ready response
//   channel.
//
//   Subtraction is done as A + ~B + 1. The "+1" is the carry register's
//   initial value.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation)
//   req_valid  request valid (op, a, b)
//   req_ready  high only while idle
//   op         0 = a + b, 1 = a - b
//   a, b       signed operands
//   rsp_valid  result and flags valid (held until rsp_ready)
//   rsp_ready  consumer accepts result
//   result     sum/difference modulo 2^WIDTH
//   overflow   signed overflow
//   carry      carry out of the MSB (subtraction: 1 = no borrow)
//   negative   result sign bit
//   zero       result == 0
// -----------------------------------------------------------------------------
module serial_addsub_flags #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow,
    output logic                    carry,
    output logic                    negative,
    output logic                    zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] sum_sh_q;   // sum bits collected so far; the newest bit enters at the top
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;

    logic signed [WIDTH-1:0] res_q;
    logic                    ovf_q;
    logic                    carry_q;
    logic                    neg_q;
    logic                    zero_q;

    logic             sum_bit;
    logic             c_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Single-bit full adder on the current LSBs
    always_comb begin
        sum_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_next   = maj(a_sh_q[0], b_sh_q[0], c_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        res_next = {sum_bit, sum_sh_q};
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_BUSY;
            S_BUSY:  if (last_bit)  state_d = S_DONE;
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
    end

    // Serial datapath. It needs no reset because every operation reloads it.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_valid) begin
            a_sh_q <= a;
            b_sh_q <= op ? ~b : b;
            c_q    <= op;
            cnt_q  <= '0;
        end else if (state_q == S_BUSY) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            sum_sh_q <= res_next[WIDTH-1:1];
            c_q      <= c_next;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Result and flags are captured once, on the MSB cycle.
    // At that point c_q is the carry into the MSB and c_next is the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state_q == S_BUSY && last_bit) begin
            res_q   <= res_next;
            ovf_q   <= c_q ^ c_next;
            carry_q <= c_next;
            neg_q   <= sum_bit;
            zero_q  <= ~|res_next;
        end
    end

    assign result   = res_q;
    assign overflow = ovf_q;
    assign carry    = carry_q;
    assign negative = neg_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub_flags.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_flags
//   Directed and randomised self-checking bench for serial_addsub_flags
//   (WIDTH = 8).
// -----------------------------------------------------------------------------
module tb_serial_addsub_flags;

    localparam int W = 8;
    localparam int N_RAND = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         carry;
    logic         negative;
    logic         zero;

    int errors = 0;
    int checks = 0;

    int          acc;
    int          done_cnt;
    int          cyc;
    int          seen;
    logic        accepted;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;

    serial_addsub_flags #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .overflow  (overflow),
        .carry     (carry),
        .negative  (negative),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
            $error("check %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: {result[7:0], overflow, carry, negative, zero}
    function automatic logic [11:0] model(input logic o, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic       v;
        logic       c;
        if (o) begin
            r = x - y;
            c = (x >= y);
            v = (x[7] != y[7]) && (r[7] != x[7]);
        end else begin
            {c, r} = {1'b0, x} + {1'b0, y};
            v = (x[7] == y[7]) && (r[7] != x[7]);
        end
        return {r, v, c, r[7], (r == 8'h00)};
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // One full transaction: accept, latency, result/flags, handshake back to idle
    task automatic do_op(input string tag, input logic o, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] er, input logic [3:0] ef);
        int n;
        req_valid = 1'b1;
        op        = o;
        a         = av;
        b         = bv;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        op        = ~o;
        a         = 8'($urandom);
        b         = 8'($urandom);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd8);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".flags"}, 32'({overflow, carry, negative, zero}), 32'(ef));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".back_idle"}, 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flags", 32'({overflow, carry, negative, zero}), 32'd0);

        // flags order: {overflow, carry, negative, zero}
        do_op("t1_add_64_32", 1'b0, 8'h64, 8'h32, 8'h96, 4'b1010);
        do_op("t2_add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 4'b1101);
        do_op("t3_sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 4'b1100);
        do_op("t3_sub_05_05", 1'b1, 8'h05, 8'h05, 8'h00, 4'b0101);
        do_op("sub_03_05",    1'b1, 8'h03, 8'h05, 8'hFE, 4'b0010);
        do_op("add_FF_01",    1'b0, 8'hFF, 8'h01, 8'h00, 4'b0101);
        do_op("sub_00_80",    1'b1, 8'h00, 8'h80, 8'h80, 4'b1010);
        do_op("sub_80_80",    1'b1, 8'h80, 8'h80, 8'h00, 4'b0101);
        do_op("add_F0_F0",    1'b0, 8'hF0, 8'hF0, 8'hE0, 4'b0110);

        // T4: backpressure and ignored requests while busy/done
        req_valid = 1'b1;
        op        = 1'b0;
        a         = 8'h10;
        b         = 8'h20;
        tick();
        a = 8'hFF;
        b = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            check("t4.busy_req_ready", 32'(req_ready), 32'd0);
            req_valid = i[0];
            tick();
        end
        req_valid = 1'b1;
        check("t4.rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t4.hold_result", 32'(result), 32'h30);
            check("t4.hold_flags", 32'({overflow, carry, negative, zero}), 32'd0);
            check("t4.hold_valid_ready", 32'({rsp_valid, req_ready}), 32'b10);
            tick();
        end
        check("t4.hold_result_end", 32'(result), 32'h30);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4.back_idle", 32'({rsp_valid, req_ready}), 32'b01);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("t4.no_ghost_response", 32'(seen), 32'd0);

        // T5: reset in the middle of an operation
        req_valid = 1'b1;
        op        = 1'b0;
        a         = 8'h11;
        b         = 8'h22;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5.req_ready", 32'(req_ready), 32'd1);
        check("t5.rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5.result", 32'(result), 32'd0);
        check("t5.flags", 32'({overflow, carry, negative, zero}), 32'd0);
        do_op("t5_add_7F_01", 1'b0, 8'h7F, 8'h01, 8'h80, 4'b1010);

        // T6: back-to-back random requests, rsp_ready tied high
        rsp_ready = 1'b1;
        acc       = 0;
        done_cnt  = 0;
        cyc       = 0;
        a         = pick();
        b         = pick();
        op        = 1'($urandom_range(0, 1));
        req_valid = 1'b1;
        while ((acc < N_RAND || done_cnt < N_RAND) && cyc < 20000) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("t6.unexpected_response", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("t6.response", 32'({result, overflow, carry, negative, zero}), 32'(exp_v));
                end
                done_cnt++;
            end
            accepted = req_valid && req_ready;
            if (accepted) begin
                exp_q.push_back(model(op, a, b));
                acc++;
            end
            tick();
            cyc++;
            if (accepted) begin
                if (acc < N_RAND) begin
                    a  = pick();
                    b  = pick();
                    op = 1'($urandom_range(0, 1));
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("t6.accepted", 32'(acc), 32'(N_RAND));
        check("t6.responses", 32'(done_cnt), 32'(N_RAND));
        check("t6.cycles", 32'(cyc), 32'(N_RAND * 10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
